// File: rtl/flags_reg_if.sv
// Bus bundle between Execute and the NZCV flags register.
// Execute drives the control and flag inputs; the register returns committed flags and stack status.
interface flags_reg_if #(
    parameter int ALU_FLAGS_WIDTH = 4,
    parameter int PTR_W           = 2
);
    logic [1:0]                 i_FlagWrite_E;
    logic                       i_CondEx_E;
    logic [ALU_FLAGS_WIDTH-1:0] i_ALUFlags;
    logic                       i_stall;
    logic                       i_push;
    logic                       i_pop;
    logic                       i_err_clr;
    logic [ALU_FLAGS_WIDTH-1:0] o_Flags_E;
    logic [PTR_W:0]             o_depth;
    logic                       o_full;
    logic                       o_empty;
    logic                       o_err;

    // Push/pop are single-cycle command pulses sampled on a non-stalled edge;
    // there is no back-pressure, misuse is reported through the sticky o_err instead.
    modport master (
        output i_FlagWrite_E, i_CondEx_E, i_ALUFlags, i_stall, i_push, i_pop, i_err_clr,
        input  o_Flags_E, o_depth, o_full, o_empty, o_err
    );

    modport slave (
        input  i_FlagWrite_E, i_CondEx_E, i_ALUFlags, i_stall, i_push, i_pop, i_err_clr,
        output o_Flags_E, o_depth, o_full, o_empty, o_err
    );
endinterface

// File: rtl/flags_reg.sv
// Architectural NZCV status register with per-group commit and an optional LIFO save/restore
// stack for interrupt entry/exit, built only when FLAGS_STACK_EN is defined.
module flags_reg #(
    parameter int  ALU_FLAGS_WIDTH = 4,
    parameter int  STACK_DEPTH     = 4,
    localparam int PTR_W           = $clog2(STACK_DEPTH)
) (
    input  logic       i_clk,
    input  logic       i_reset,
    flags_reg_if.slave bus
);
    localparam int W = ALU_FLAGS_WIDTH;

    logic [W-1:0] flags_q;
    logic [W-1:0] flags_d;
    logic [W-1:0] flags_wr;
    logic         we_nz;
    logic         we_cv;

    assign we_nz = bus.i_FlagWrite_E[1] & bus.i_CondEx_E & ~bus.i_stall;
    assign we_cv = bus.i_FlagWrite_E[0] & bus.i_CondEx_E & ~bus.i_stall;

    // N,Z live in the top two bits, C,V in the bottom two; each group commits independently.
    always_comb begin
        flags_wr = flags_q;
        if (we_nz) flags_wr[W-1:W-2] = bus.i_ALUFlags[W-1:W-2];
        if (we_cv) flags_wr[1:0]     = bus.i_ALUFlags[1:0];
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) flags_q <= '0;
        else          flags_q <= flags_d;
    end

    assign bus.o_Flags_E = flags_q;

`ifdef FLAGS_STACK_EN
    logic [PTR_W:0] depth_q;
    logic [PTR_W:0] depth_d;
    logic [PTR_W:0] depth_m1;
    logic           err_q;
    logic           err_d;
    logic [W-1:0]   stack_q [STACK_DEPTH];
    logic           full;
    logic           empty;
    logic           push_ok;
    logic           pop_ok;
    logic           err_ev;
    logic           unused_msb;

    assign full     = (depth_q == (PTR_W+1)'(STACK_DEPTH));
    assign empty    = (depth_q == '0);
    assign depth_m1 = depth_q - 1'b1;
    assign push_ok  = bus.i_push & ~bus.i_pop & ~full  & ~bus.i_stall;
    assign pop_ok   = bus.i_pop  & ~bus.i_push & ~empty & ~bus.i_stall;
    assign err_ev   = ~bus.i_stall & ((bus.i_push & bus.i_pop) |
                                      (bus.i_push & full) | (bus.i_pop & empty));
    assign unused_msb = depth_m1[PTR_W];

    // A successful pop overrides any same-cycle flag write.
    always_comb begin
        flags_d = flags_wr;
        depth_d = depth_q;
        err_d   = err_q;
        if (pop_ok) begin
            flags_d = stack_q[depth_m1[PTR_W-1:0]];
            depth_d = depth_m1;
        end else if (push_ok) begin
            depth_d = depth_q + 1'b1;
        end
        if (err_ev)                          err_d = 1'b1;
        else if (bus.i_err_clr & ~bus.i_stall) err_d = 1'b0;
    end

    // Push saves the pre-write flags, not the value being committed this cycle.
    always_ff @(posedge i_clk) begin
        if (push_ok) stack_q[depth_q[PTR_W-1:0]] <= flags_q;
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            depth_q <= '0;
            err_q   <= 1'b0;
        end else begin
            depth_q <= depth_d;
            err_q   <= err_d;
        end
    end

    assign bus.o_depth = depth_q;
    assign bus.o_full  = full;
    assign bus.o_empty = empty;
    assign bus.o_err   = err_q;
`else
    logic unused_stack_ctl;

    assign flags_d          = flags_wr;
    assign unused_stack_ctl = ^{bus.i_push, bus.i_pop, bus.i_err_clr};
    assign bus.o_depth      = '0;
    assign bus.o_full       = 1'b0;
    assign bus.o_empty      = 1'b1;
    assign bus.o_err        = 1'b0;
`endif
endmodule

// File: tb/tb_flags_reg.sv
// Bench for flags_reg: constant vector table, hand sequences for stack corners, async reset,
// and random traffic against a queue-based reference model.
module tb_flags_reg;
    localparam int DEPTH = 4;
`ifdef FLAGS_STACK_EN
    localparam bit STACK_EN = 1'b1;
`else
    localparam bit STACK_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    flags_reg_if #(.ALU_FLAGS_WIDTH(4), .PTR_W(2)) bus ();

    flags_reg #(.ALU_FLAGS_WIDTH(4), .STACK_DEPTH(DEPTH)) dut (
        .i_clk   (clk),
        .i_reset (rst_n),
        .bus     (bus.slave)
    );

    int total = 0;
    int bad   = 0;

    logic [3:0] m_flags;
    logic       m_err;
    logic [3:0] m_stk [$];

    typedef struct {
        logic [1:0] fw;
        logic       cx;
        logic [3:0] alu;
        logic       stall;
        logic [3:0] exp_flags;
    } vec_t;
    vec_t tbl [6];

    task automatic check_val(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic check_model(input string name);
        check_val({name, ".flags"}, int'(bus.o_Flags_E), int'(m_flags));
        check_val({name, ".depth"}, int'(bus.o_depth), m_stk.size());
        check_val({name, ".full"},  int'(bus.o_full),  int'(m_stk.size() == DEPTH));
        check_val({name, ".empty"}, int'(bus.o_empty), int'(m_stk.size() == 0));
        check_val({name, ".err"},   int'(bus.o_err),   int'(m_err));
    endtask

    task automatic model_reset();
        m_flags = 4'b0000;
        m_err   = 1'b0;
        m_stk.delete();
    endtask

    // Reference: flags first, then the stack rules; a successful pop replaces the new flags.
    task automatic model_step(input logic [1:0] fw, input logic cx, input logic [3:0] alu,
                              input logic push, input logic pop, input logic clr,
                              input logic stall);
        logic [3:0] nf;
        bit         ev;
        if (stall) return;
        nf = m_flags;
        if (fw[1] && cx) nf[3:2] = alu[3:2];
        if (fw[0] && cx) nf[1:0] = alu[1:0];
        if (STACK_EN) begin
            ev = 1'b0;
            if (push && pop) ev = 1'b1;
            else if (push) begin
                if (m_stk.size() == DEPTH) ev = 1'b1;
                else m_stk.push_back(m_flags);
            end else if (pop) begin
                if (m_stk.size() == 0) ev = 1'b1;
                else nf = m_stk.pop_back();
            end
            if (ev) m_err = 1'b1;
            else if (clr) m_err = 1'b0;
        end
        m_flags = nf;
    endtask

    task automatic cyc(input logic [1:0] fw, input logic cx, input logic [3:0] alu,
                       input logic push, input logic pop, input logic clr, input logic stall,
                       input string name);
        bus.i_FlagWrite_E = fw;
        bus.i_CondEx_E    = cx;
        bus.i_ALUFlags    = alu;
        bus.i_push        = push;
        bus.i_pop         = pop;
        bus.i_err_clr     = clr;
        bus.i_stall       = stall;
        model_step(fw, cx, alu, push, pop, clr, stall);
        @(posedge clk);
        #1;
        check_model(name);
    endtask

    initial begin
        tbl[0] = '{fw: 2'b11, cx: 1'b1, alu: 4'b1010, stall: 1'b0, exp_flags: 4'b1010};
        tbl[1] = '{fw: 2'b10, cx: 1'b1, alu: 4'b0101, stall: 1'b0, exp_flags: 4'b0110};
        tbl[2] = '{fw: 2'b01, cx: 1'b1, alu: 4'b1001, stall: 1'b0, exp_flags: 4'b0101};
        tbl[3] = '{fw: 2'b11, cx: 1'b0, alu: 4'b1111, stall: 1'b0, exp_flags: 4'b0101};
        tbl[4] = '{fw: 2'b11, cx: 1'b1, alu: 4'b0000, stall: 1'b1, exp_flags: 4'b0101};
        tbl[5] = '{fw: 2'b00, cx: 1'b1, alu: 4'b1111, stall: 1'b0, exp_flags: 4'b0101};

        bus.i_FlagWrite_E = 2'b00;
        bus.i_CondEx_E    = 1'b0;
        bus.i_ALUFlags    = 4'b0000;
        bus.i_push        = 1'b0;
        bus.i_pop         = 1'b0;
        bus.i_err_clr     = 1'b0;
        bus.i_stall       = 1'b0;
        model_reset();

        repeat (2) @(posedge clk);
        #1;
        check_val("reset.flags", int'(bus.o_Flags_E), 0);
        check_val("reset.depth", int'(bus.o_depth), 0);
        check_val("reset.empty", int'(bus.o_empty), 1);
        check_val("reset.full",  int'(bus.o_full), 0);
        check_val("reset.err",   int'(bus.o_err), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Flag-only vectors; expectations are constants from the table.
        for (int i = 0; i < 6; i++) begin
            bus.i_FlagWrite_E = tbl[i].fw;
            bus.i_CondEx_E    = tbl[i].cx;
            bus.i_ALUFlags    = tbl[i].alu;
            bus.i_stall       = tbl[i].stall;
            #1;
            if (i == 0) check_val("vec0.before_edge", int'(bus.o_Flags_E), 0);
            model_step(tbl[i].fw, tbl[i].cx, tbl[i].alu, 1'b0, 1'b0, 1'b0, tbl[i].stall);
            @(posedge clk);
            #1;
            check_val($sformatf("vec%0d.flags", i), int'(bus.o_Flags_E), int'(tbl[i].exp_flags));
            check_val($sformatf("vec%0d.depth", i), int'(bus.o_depth), 0);
            check_val($sformatf("vec%0d.err", i), int'(bus.o_err), 0);
        end

        // Push with same-cycle write, then pop restores the pre-write value.
        cyc(2'b11, 1'b1, 4'b1111, 1'b1, 1'b0, 1'b0, 1'b0, "push_wr");
        check_val("push_wr.const_flags", int'(bus.o_Flags_E), 4'b1111);
        cyc(2'b11, 1'b1, 4'b1000, 1'b0, 1'b1, 1'b0, 1'b0, "pop_prio");
`ifdef FLAGS_STACK_EN
        check_val("pop_prio.const_flags", int'(bus.o_Flags_E), 4'b0101);
        check_val("pop_prio.const_empty", int'(bus.o_empty), 1);
`endif

        // Fill, overflow, drain in LIFO order, underflow, clear.
        cyc(2'b11, 1'b1, 4'b0001, 1'b1, 1'b0, 1'b0, 1'b0, "fill0");
        cyc(2'b11, 1'b1, 4'b0010, 1'b1, 1'b0, 1'b0, 1'b0, "fill1");
        cyc(2'b11, 1'b1, 4'b0011, 1'b1, 1'b0, 1'b0, 1'b0, "fill2");
        cyc(2'b11, 1'b1, 4'b0100, 1'b1, 1'b0, 1'b0, 1'b0, "fill3");
        cyc(2'b11, 1'b1, 4'b0110, 1'b1, 1'b0, 1'b0, 1'b0, "overflow");
`ifdef FLAGS_STACK_EN
        check_val("overflow.const_depth", int'(bus.o_depth), 4);
        check_val("overflow.const_err", int'(bus.o_err), 1);
`endif
        for (int i = 0; i < 4; i++)
            cyc(2'b00, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, $sformatf("drain%0d", i));
`ifdef FLAGS_STACK_EN
        check_val("drain.const_last", int'(bus.o_Flags_E), 4'b0101);
`endif
        cyc(2'b11, 1'b1, 4'b1110, 1'b0, 1'b1, 1'b0, 1'b0, "underflow");
        cyc(2'b00, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b1, "clr_stalled");
        cyc(2'b00, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, "err_clr");
        cyc(2'b00, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b1, 1'b0, "clr_vs_set");
        cyc(2'b00, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, "err_clr2");

        // Illegal push+pop, then stalled push+write.
        cyc(2'b11, 1'b1, 4'b1010, 1'b1, 1'b0, 1'b0, 1'b0, "pre_illegal");
        cyc(2'b11, 1'b1, 4'b0011, 1'b1, 1'b1, 1'b0, 1'b0, "illegal");
        check_val("illegal.const_flags", int'(bus.o_Flags_E), 4'b0011);
        cyc(2'b11, 1'b1, 4'b1111, 1'b1, 1'b0, 1'b1, 1'b1, "stall_all");

        // Async reset mid-cycle with a non-trivial state.
        cyc(2'b00, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, "pre_rst_clr");
        cyc(2'b00, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, "pre_rst_push1");
        cyc(2'b11, 1'b1, 4'b1100, 1'b1, 1'b0, 1'b0, 1'b0, "pre_rst_push2");
        check_val("pre_rst.const_flags", int'(bus.o_Flags_E), 4'b1100);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("async_rst.flags", int'(bus.o_Flags_E), 0);
        check_val("async_rst.depth", int'(bus.o_depth), 0);
        check_val("async_rst.empty", int'(bus.o_empty), 1);
        check_val("async_rst.full",  int'(bus.o_full), 0);
        check_val("async_rst.err",   int'(bus.o_err), 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        cyc(2'b01, 1'b1, 4'b0111, 1'b0, 1'b0, 1'b0, 1'b0, "post_rst");

        for (int n = 0; n < 400; n++) begin
            cyc(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 2) == 0),
                1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 7) == 0),
                $sformatf("rand%0d", n));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
